// File: rtl/vga_timing_pinout.sv
// 800x600@60 VGA timing generator with TinyVGA uo_out pin packing; optional colour-bar source (VGA_TEST_PATTERN_EN).
// Latency: hpos/vpos/display_on/line_start/frame_start are combinational; uo_out lags hpos by PIPE_LAT+1 clk.
// Backpressure: none; ena=0 freezes counters, alignment pipe and uo_out (rst_n still wins).
module vga_timing_pinout #(
    parameter int   H_ACTIVE  = 800,
    parameter int   H_FP      = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BP      = 88,
    parameter int   V_ACTIVE  = 600,
    parameter int   V_FP      = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BP      = 23,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1,
    parameter int   PIPE_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_en,
`endif
    input  logic [5:0]  rgb_in,
    output logic [10:0] hpos,
    output logic [9:0]  vpos,
    output logic        display_on,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  uo_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Pipe word carries {hsync, vsync, display_on}, plus hpos when the bar pattern needs it.
`ifdef VGA_TEST_PATTERN_EN
    localparam int PW = 14;
`else
    localparam int PW = 3;
`endif

    logic          hsync_raw;
    logic          vsync_raw;
    logic [PW-1:0] pipe_in;
    logic [PW-1:0] pipe_out;
    logic          hsync_d;
    logic          vsync_d;
    logic          de_d;
    logic [5:0]    colour;

    // Pixel/line counters; the line counter steps only on the last pixel of a line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos <= '0;
            vpos <= '0;
        end else if (ena) begin
            if (hpos == 11'(H_TOTAL - 1)) begin
                hpos <= '0;
                if (vpos == 10'(V_TOTAL - 1)) vpos <= '0;
                else                          vpos <= vpos + 10'd1;
            end else begin
                hpos <= hpos + 11'd1;
            end
        end
    end

    // Zero-latency timing decode straight from the counters.
    always_comb begin
        display_on  = (hpos < 11'(H_ACTIVE)) && (vpos < 10'(V_ACTIVE));
        line_start  = (hpos == 11'd0);
        frame_start = (hpos == 11'd0) && (vpos == 10'd0);
        hsync_raw   = (hpos >= 11'(H_ACTIVE + H_FP)) && (hpos < 11'(H_ACTIVE + H_FP + H_SYNC));
        vsync_raw   = (vpos >= 10'(V_ACTIVE + V_FP)) && (vpos < 10'(V_ACTIVE + V_FP + V_SYNC));
`ifdef VGA_TEST_PATTERN_EN
        pipe_in     = {hpos, hsync_raw, vsync_raw, display_on};
`else
        pipe_in     = {hsync_raw, vsync_raw, display_on};
`endif
    end

    // Alignment delay so sync/blank meet the pixel logic's colour; stages hold raw (pre-polarity) flags.
    generate
        if (PIPE_LAT == 0) begin : g_nodelay
            assign pipe_out = pipe_in;
        end else begin : g_delay
            logic [PW-1:0] stage [PIPE_LAT];

            // Shift one stage per enabled clock; reset flushes to inactive/blank.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_LAT; i++) stage[i] <= '0;
                end else if (ena) begin
                    stage[0] <= pipe_in;
                    for (int i = 1; i < PIPE_LAT; i++) stage[i] <= stage[i-1];
                end
            end

            assign pipe_out = stage[PIPE_LAT-1];
        end
    endgenerate

    assign hsync_d = pipe_out[2];
    assign vsync_d = pipe_out[1];
    assign de_d    = pipe_out[0];

`ifdef VGA_TEST_PATTERN_EN
    logic [10:0] hpos_d;
    logic [2:0]  bar_idx;

    assign hpos_d = pipe_out[13:3];

    // 100-pixel bars: index is the number of 100-px boundaries passed by the delayed column.
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (hpos_d >= 11'(k * 100)) bar_idx = 3'(k);
        end
    end
`endif

    // Colour source select and blanking.
    always_comb begin
        colour = '0;
        if (de_d) begin
`ifdef VGA_TEST_PATTERN_EN
            if (test_en) colour = {bar_idx[0], bar_idx[0], bar_idx[1], bar_idx[1], bar_idx[2], bar_idx[2]};
            else         colour = rgb_in;
`else
            colour = rgb_in;
`endif
        end
    end

    // TinyVGA pin word {hsync,B0,G0,R0,vsync,B1,G1,R1}; colour is {R1,R0,G1,G0,B1,B0}.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uo_out <= {~HSYNC_POL, 3'b000, ~VSYNC_POL, 3'b000};
        end else if (ena) begin
            uo_out <= {(hsync_d ? HSYNC_POL : ~HSYNC_POL), colour[0], colour[2], colour[4],
                       (vsync_d ? VSYNC_POL : ~VSYNC_POL), colour[1], colour[3], colour[5]};
        end
    end

endmodule
